vga_video_pipe: RTL and testbench

- Parametrised successor to the fixed 640x480 bitplane video generator.
- Generates VGA timing with configurable geometry and sync polarity.
- Pops packed pixel words from the upstream video FIFO and unpacks 1/2/4/8/16 bpp into 24-bit RGB, with aligned hsync/vsync/data-enable.
- Feeds both the analog VGA pins and the downstream TMDS encoder stage; has no TMDS logic of its own.

---
 rtl/vga_video_pkg.sv | 62 ++++++
 rtl/vga_timing_gen.sv | 79 +++++++
 rtl/vga_video_pipe.sv | 174 +++++++++++++++++
 tb/tb_vga_video_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_video_pkg.sv
// vga_video_pkg: shared constants and helpers for the VGA video pipe
// (frame geometry, sync polarity, colour expansion per bits-per-pixel).
package vga_video_pkg;

    localparam int BPP_1  = 1;
    localparam int BPP_2  = 2;
    localparam int BPP_4  = 4;
    localparam int BPP_8  = 8;
    localparam int BPP_16 = 16;

    function automatic int vga_frame_len(input int vis, input int fp,
                                         input int pulse, input int bp);
        return vis + fp + pulse + bp;
    endfunction

    function automatic int vga_cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    function automatic logic vga_sync_level(input logic active, input int pol);
        return active ? (pol != 0) : (pol == 0);
    endfunction

    function automatic logic [23:0] vga_expand(input logic [15:0] p, input int bpp);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = '0;
        g = '0;
        b = '0;
        case (bpp)
            BPP_16: begin
                r = {p[15:11], p[15:13]};
                g = {p[10:5], p[10:9]};
                b = {p[4:0], p[4:2]};
            end
            BPP_8: begin
                r = {p[7:5], p[7:5], p[7:6]};
                g = {p[4:2], p[4:2], p[4:3]};
                b = {4{p[1:0]}};
            end
            BPP_4: begin
                r = p[2] ? {p[3], 7'h7F} : 8'h00;
                g = p[1] ? {p[3], 7'h7F} : 8'h00;
                b = p[0] ? {p[3], 7'h7F} : 8'h00;
            end
            BPP_2: begin
                r = 8'(p[1:0]) * 8'h55;
                g = r;
                b = r;
            end
            BPP_1: begin
                r = p[0] ? 8'hFF : 8'h00;
                g = r;
                b = r;
            end
            default: ;
        endcase
        return {r, g, b};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters plus the strobes derived from them
// (sync windows, active area, frame start, line repeat).
module vga_timing_gen
    import vga_video_pkg::*;
#(
    parameter int C_resolution_x      = 640,
    parameter int C_hsync_front_porch = 16,
    parameter int C_hsync_pulse       = 96,
    parameter int C_hsync_back_porch  = 48,
    parameter int C_resolution_y      = 480,
    parameter int C_vsync_front_porch = 10,
    parameter int C_vsync_pulse       = 2,
    parameter int C_vsync_back_porch  = 33,
    parameter int C_dbl_y             = 0,
    parameter int CXW                 = 10,
    parameter int CYW                 = 10
) (
    input  logic           clk_pixel,
    input  logic           resetn,
`ifdef VGA_VIDEO_PIPE_TEST_PATTERN_EN
    output logic [CXW-1:0] cx_o,
`endif
    output logic           cx_lsb_o,
    output logic           act_o,
    output logic           hs_act_o,
    output logic           vs_act_o,
    output logic           frame_start_o,
    output logic           line_repeat_o
);

    localparam int FX = vga_frame_len(C_resolution_x, C_hsync_front_porch,
                                      C_hsync_pulse, C_hsync_back_porch);
    localparam int FY = vga_frame_len(C_resolution_y, C_vsync_front_porch,
                                      C_vsync_pulse, C_vsync_back_porch);
    localparam int HS0 = C_resolution_x + C_hsync_front_porch;
    localparam int HS1 = HS0 + C_hsync_pulse;
    localparam int VS0 = C_resolution_y + C_vsync_front_porch;
    localparam int VS1 = VS0 + C_vsync_pulse;

    logic [CXW-1:0] cx_q, cx_d;
    logic [CYW-1:0] cy_q, cy_d;
    int             cxi;
    int             cyi;

    assign cxi = int'(cx_q);
    assign cyi = int'(cy_q);

    always_comb begin
        cx_d = cx_q + 1'b1;
        cy_d = cy_q;
        if (cxi == FX - 1) begin
            cx_d = '0;
            cy_d = (cyi == FY - 1) ? '0 : cy_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!resetn) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

`ifdef VGA_VIDEO_PIPE_TEST_PATTERN_EN
    assign cx_o = cx_q;
`endif
    assign cx_lsb_o      = cx_q[0];
    assign act_o         = (cxi < C_resolution_x) && (cyi < C_resolution_y);
    assign hs_act_o      = (cxi >= HS0) && (cxi < HS1);
    assign vs_act_o      = (cyi >= VS0) && (cyi < VS1);
    assign frame_start_o = (cxi == 0) && (cyi == C_resolution_y);
    // Even visible lines are replayed once more by rewinding the FIFO.
    assign line_repeat_o = (C_dbl_y != 0) && (cxi == C_resolution_x)
                           && (cyi < C_resolution_y) && !cy_q[0];

endmodule

// File: rtl/vga_video_pipe.sv
// vga_video_pipe: VGA timing plus FIFO word fetch, pixel unpack and colour
// expansion. Optional colour bars via VGA_VIDEO_PIPE_TEST_PATTERN_EN.
module vga_video_pipe
    import vga_video_pkg::*;
#(
    parameter int C_resolution_x      = 640,
    parameter int C_hsync_front_porch = 16,
    parameter int C_hsync_pulse       = 96,
    parameter int C_hsync_back_porch  = 48,
    parameter int C_resolution_y      = 480,
    parameter int C_vsync_front_porch = 10,
    parameter int C_vsync_pulse       = 2,
    parameter int C_vsync_back_porch  = 33,
    parameter int C_hsync_polarity    = 0,
    parameter int C_vsync_polarity    = 0,
    parameter int C_fetch_width       = 32,
    parameter int C_bpp               = 8,
    parameter int C_dbl_x             = 0,
    parameter int C_dbl_y             = 0
) (
    input  logic                     clk_pixel,
    input  logic                     resetn,
    input  logic [C_fetch_width-1:0] fetch_data,
    input  logic                     fetch_valid,
`ifdef VGA_VIDEO_PIPE_TEST_PATTERN_EN
    input  logic                     test_pattern,
`endif
    output logic                     fetch_next,
    output logic                     line_repeat,
    output logic                     frame_start,
    output logic                     underflow,
    output logic [7:0]               vga_r,
    output logic [7:0]               vga_g,
    output logic [7:0]               vga_b,
    output logic                     vga_hsync,
    output logic                     vga_vsync,
    output logic                     vga_de
);

    localparam int FX = vga_frame_len(C_resolution_x, C_hsync_front_porch,
                                      C_hsync_pulse, C_hsync_back_porch);
    localparam int FY = vga_frame_len(C_resolution_y, C_vsync_front_porch,
                                      C_vsync_pulse, C_vsync_back_porch);
    localparam int CXW    = vga_cnt_width(FX);
    localparam int CYW    = vga_cnt_width(FY);
    localparam int PPW    = C_fetch_width / C_bpp;
    localparam int PERIOD = PPW << C_dbl_x;
    localparam int PHW    = vga_cnt_width(PERIOD);

    logic act, hs_act, vs_act, fs_now, lr_now, cx_lsb;
    logic load, shift_en;
    logic [PHW-1:0]           ph_q, ph_d;
    logic [C_fetch_width-1:0] sh_q, sh_d, cur;
    logic [15:0]              pix;
    logic [23:0]              rgb_q, rgb_d;
    logic de_q, hs_q, vs_q, fn_q, lr_q, fs_q;
    logic underflow_q, underflow_d;
`ifdef VGA_VIDEO_PIPE_TEST_PATTERN_EN
    logic [CXW-1:0] cx;
    logic [2:0]     bar;
`endif

    vga_timing_gen #(
        .C_resolution_x      (C_resolution_x),
        .C_hsync_front_porch (C_hsync_front_porch),
        .C_hsync_pulse       (C_hsync_pulse),
        .C_hsync_back_porch  (C_hsync_back_porch),
        .C_resolution_y      (C_resolution_y),
        .C_vsync_front_porch (C_vsync_front_porch),
        .C_vsync_pulse       (C_vsync_pulse),
        .C_vsync_back_porch  (C_vsync_back_porch),
        .C_dbl_y             (C_dbl_y),
        .CXW                 (CXW),
        .CYW                 (CYW)
    ) u_timing (
        .clk_pixel     (clk_pixel),
        .resetn        (resetn),
`ifdef VGA_VIDEO_PIPE_TEST_PATTERN_EN
        .cx_o          (cx),
`endif
        .cx_lsb_o      (cx_lsb),
        .act_o         (act),
        .hs_act_o      (hs_act),
        .vs_act_o      (vs_act),
        .frame_start_o (fs_now),
        .line_repeat_o (lr_now)
    );

    // Word phase restarts at every line start, so it tracks cx mod PERIOD.
    assign load     = act && (ph_q == '0);
    assign shift_en = (C_dbl_x == 0) || cx_lsb;
    assign pix      = 16'(cur[C_bpp-1:0]);

    always_comb begin
        ph_d = ph_q + 1'b1;
        if (!act || int'(ph_q) == PERIOD - 1) begin
            ph_d = '0;
        end
    end

    always_comb begin
        cur = sh_q;
        if (load) begin
            cur = fetch_valid ? fetch_data : '0;
        end
        sh_d = sh_q;
        if (act) begin
            sh_d = shift_en ? (cur >> C_bpp) : cur;
        end
    end

    always_comb begin
        underflow_d = underflow_q;
        if (fs_now) begin
            underflow_d = 1'b0;
        end else if (load && !fetch_valid) begin
            underflow_d = 1'b1;
        end
    end

`ifdef VGA_VIDEO_PIPE_TEST_PATTERN_EN
    assign bar = 3'((int'(cx) * 8) / C_resolution_x);
`endif

    always_comb begin
        rgb_d = '0;
        if (act) begin
            rgb_d = vga_expand(pix, C_bpp);
        end
`ifdef VGA_VIDEO_PIPE_TEST_PATTERN_EN
        if (act && test_pattern) begin
            rgb_d = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
        end
`endif
    end

    always_ff @(posedge clk_pixel) begin
        if (!resetn) begin
            ph_q        <= '0;
            sh_q        <= '0;
            rgb_q       <= '0;
            de_q        <= 1'b0;
            hs_q        <= vga_sync_level(1'b0, C_hsync_polarity);
            vs_q        <= vga_sync_level(1'b0, C_vsync_polarity);
            fn_q        <= 1'b0;
            lr_q        <= 1'b0;
            fs_q        <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            sh_q        <= sh_d;
            rgb_q       <= rgb_d;
            de_q        <= act;
            hs_q        <= vga_sync_level(hs_act, C_hsync_polarity);
            vs_q        <= vga_sync_level(vs_act, C_vsync_polarity);
            fn_q        <= load && fetch_valid;
            lr_q        <= lr_now;
            fs_q        <= fs_now;
            underflow_q <= underflow_d;
        end
    end

    assign fetch_next  = fn_q;
    assign line_repeat = lr_q;
    assign frame_start = fs_q;
    assign underflow   = underflow_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign vga_de      = de_q;

endmodule

// File: tb/tb_vga_video_pipe.sv
// tb_vga_video_pipe: five pipe configurations on a small raster, randomized
// FIFO behaviour, per-cycle scoreboard against a raster-level model.
module tb_vga_video_pipe;

    localparam int RX = 32, HFP = 4, HPW = 8, HBP = 4;
    localparam int RY = 8, VFP = 2, VPW = 2, VBP = 2;
    localparam int FX = RX + HFP + HPW + HBP;
    localparam int FY = RY + VFP + VPW + VBP;
    localparam int MIDRST = 3 + FX * FY + 3 * FX + 20;
    localparam int ENDC = 3 + 3 * FX * FY + 60;

    typedef struct packed {
        logic [23:0] rgb;
        logic hs, vs, de, fn, lr, fs, uf;
    } obs_t;

    typedef struct {
        obs_t o;
        int   x;
        int   y;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // {bpp, fetch width, dbl_x, dbl_y, hsync pol, vsync pol}
    function automatic logic [31:0] cfg(input int k);
        case (k)
            0: return {8'd8,  8'd32, 4'd0, 4'd0, 4'd0, 4'd0};
            1: return {8'd16, 8'd32, 4'd1, 4'd1, 4'd1, 4'd1};
            2: return {8'd4,  8'd16, 4'd0, 4'd1, 4'd1, 4'd0};
            3: return {8'd2,  8'd16, 4'd1, 4'd0, 4'd0, 4'd1};
            default: return {8'd1, 8'd32, 4'd0, 4'd0, 4'd0, 4'd0};
        endcase
    endfunction

    function automatic logic [31:0] dword(input int k);
        case (k)
            0: return 32'h00E01CFF;
            1: return 32'h001FF800;
            2: return 32'h0000C3A5;
            3: return 32'h0000E41B;
            default: return 32'hA5A50F0F;
        endcase
    endfunction

    function automatic logic [23:0] ref_rgb(input int p, input int b);
        int r, g, bl, i;
        r = 0; g = 0; bl = 0;
        case (b)
            16: begin
                r  = (p >> 11) & 31; g = (p >> 5) & 63; bl = p & 31;
                r  = (r << 3) | (r >> 2);
                g  = (g << 2) | (g >> 4);
                bl = (bl << 3) | (bl >> 2);
            end
            8: begin
                r  = (p >> 5) & 7; g = (p >> 2) & 7; bl = p & 3;
                r  = (r << 5) | (r << 2) | (r >> 1);
                g  = (g << 5) | (g << 2) | (g >> 1);
                bl = bl * 85;
            end
            4: begin
                i  = ((p >> 3) & 1) != 0 ? 255 : 127;
                r  = (p & 4) != 0 ? i : 0;
                g  = (p & 2) != 0 ? i : 0;
                bl = (p & 1) != 0 ? i : 0;
            end
            2: begin
                r = p * 85; g = r; bl = r;
            end
            default: begin
                r = (p != 0) ? 255 : 0; g = r; bl = r;
            end
        endcase
        return {8'(r), 8'(g), 8'(bl)};
    endfunction

    for (genvar k = 0; k < 5; k++) begin : g
        localparam logic [31:0] C = cfg(k);
        localparam int B   = int'(C[31:24]);
        localparam int FW  = int'(C[23:16]);
        localparam int DX  = int'(C[15:12]);
        localparam int DY  = int'(C[11:8]);
        localparam int HP  = int'(C[7:4]);
        localparam int VP  = int'(C[3:0]);
        localparam int PPW = FW / B;
        localparam int PER = PPW << DX;

        logic [FW-1:0] fd;
        logic [FW-1:0] word;
        logic          fv;
        logic [7:0]    r, gr, bl;
        logic          hs, vs, de, fn, lr, fs, uf;
        exp_t          q[$];
        int            bx, by, frm;
        logic          ufm, pend;

        vga_video_pipe #(
            .C_resolution_x      (RX),
            .C_hsync_front_porch (HFP),
            .C_hsync_pulse       (HPW),
            .C_hsync_back_porch  (HBP),
            .C_resolution_y      (RY),
            .C_vsync_front_porch (VFP),
            .C_vsync_pulse       (VPW),
            .C_vsync_back_porch  (VBP),
            .C_hsync_polarity    (HP),
            .C_vsync_polarity    (VP),
            .C_fetch_width       (FW),
            .C_bpp               (B),
            .C_dbl_x             (DX),
            .C_dbl_y             (DY)
        ) dut (
            .clk_pixel   (clk),
            .resetn      (resetn),
            .fetch_data  (fd),
            .fetch_valid (fv),
`ifdef VGA_VIDEO_PIPE_TEST_PATTERN_EN
            .test_pattern(1'b0),
`endif
            .fetch_next  (fn),
            .line_repeat (lr),
            .frame_start (fs),
            .underflow   (uf),
            .vga_r       (r),
            .vga_g       (gr),
            .vga_b       (bl),
            .vga_hsync   (hs),
            .vga_vsync   (vs),
            .vga_de      (de)
        );

        initial begin
            fd   = FW'(dword(k));
            fv   = 1'b1;
            word = '0;
            bx   = 0;
            by   = 0;
            frm  = 0;
            ufm  = 1'b0;
            pend = 1'b0;
        end

        // FIFO model plus expectation for the raster position of this cycle.
        always @(negedge clk) begin : stim
            exp_t          e;
            int            slot, p;
            logic [FW-1:0] t;
            logic          act, ld;
            if (pend) fd = (frm == 0) ? FW'(dword(k)) : FW'($urandom);
            pend = (fn === 1'b1);
            fv = (frm == 0) || ($urandom_range(0, 7) != 0);
            e.x = bx;
            e.y = by;
            e.o = '0;
            if (!resetn) begin
                e.o.hs = (HP == 0);
                e.o.vs = (VP == 0);
                ufm = 1'b0;
                bx = 0;
                by = 0;
            end else begin
                act = (bx < RX) && (by < RY);
                ld  = act && (bx % PER == 0);
                if (bx == 0 && by == RY) ufm = 1'b0;
                if (ld) begin
                    word = fv ? fd : '0;
                    if (!fv) ufm = 1'b1;
                end
                if (act) begin
                    slot = (bx % PER) >> DX;
                    t = word >> (slot * B);
                    p = 0;
                    for (int i = 0; i < B; i++) if (t[i]) p += (1 << i);
                    e.o.rgb = ref_rgb(p, B);
                end
                e.o.de = act;
                e.o.fn = ld && fv;
                e.o.hs = (bx >= RX + HFP && bx < RX + HFP + HPW) ? (HP != 0) : (HP == 0);
                e.o.vs = (by >= RY + VFP && by < RY + VFP + VPW) ? (VP != 0) : (VP == 0);
                e.o.lr = (DY != 0) && bx == RX && by < RY && (by % 2 == 0);
                e.o.fs = (bx == 0) && (by == RY);
                e.o.uf = ufm;
                bx++;
                if (bx == FX) begin
                    bx = 0;
                    by++;
                    if (by == FY) begin
                        by = 0;
                        frm++;
                    end
                end
            end
            q.push_back(e);
        end

        always @(posedge clk) begin : mon
            exp_t e;
            obs_t a;
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a.rgb = {r, gr, bl};
                a.hs = hs; a.vs = vs; a.de = de; a.fn = fn;
                a.lr = lr; a.fs = fs; a.uf = uf;
                tests++;
                if (a !== e.o) begin
                    fails++;
                    $display("FAIL inst%0d pos x=%0d y=%0d: got rgb=%h hs,vs,de,fn,lr,fs,uf=%b%b%b%b%b%b%b, want rgb=%h hs,vs,de,fn,lr,fs,uf=%b%b%b%b%b%b%b",
                             k, e.x, e.y, a.rgb, a.hs, a.vs, a.de, a.fn, a.lr, a.fs, a.uf,
                             e.o.rgb, e.o.hs, e.o.vs, e.o.de, e.o.fn, e.o.lr, e.o.fs, e.o.uf);
                end
            end
        end
    end

    initial begin
        repeat (ENDC) begin
            @(posedge clk);
            #2;
            cyc++;
            resetn = !(cyc < 3 || cyc == MIDRST);
        end
        @(posedge clk);
        #3;
        if (tests < 12) begin
            fails++;
            $display("FAIL check count: got %0d, need at least 12", tests);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
